// File: rtl/wb_pkg.sv
// Shared widths and state encoding for the write-back port arbiter.
package wb_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [0:0] {
        WB_IDLE = 1'b0,
        WB_WAIT = 1'b1
    } wb_state_e;
endpackage

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the in-order pipeline and one
// long-latency result source; replaces the MEM/WB register.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    localparam int CW = $clog2(MAX_WAIT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_valid,
    input  logic              pipe_is_write,
    input  logic [REG_AW-1:0] pipe_rd,
    input  logic [XLEN-1:0]   pipe_data,
    output logic              pipe_stall,
    input  logic              ml_valid,
    input  logic [REG_AW-1:0] ml_rd,
    input  logic [XLEN-1:0]   ml_data,
    output logic              ml_ready,
    output logic [XLEN-1:0]   wb_data_out,
    output logic [REG_AW-1:0] rd_out,
    output logic              is_write_out,
    output wb_state_e         dbg_state,
    output logic [CW-1:0]     dbg_wait_cnt,
    output logic              dbg_kill
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    wb_state_e       state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            kill_q, kill_d;
    logic            pipe_wr, at_max, grant_ml, force_stall;

    // Handshake: ml_data/ml_rd transfer on a cycle where ml_valid && ml_ready;
    // the source holds them stable until then. pipe_stall asks the pipeline to
    // re-present the same MEM inputs on the following cycle.
    always_comb begin
        pipe_wr     = pipe_valid && pipe_is_write && (pipe_rd != '0);
        at_max      = (wait_cnt_q == MAX_CNT);
        grant_ml    = reset && ml_valid && (!pipe_wr || at_max);
        force_stall = reset && ml_valid && pipe_wr && at_max;
        ml_ready    = grant_ml;
        pipe_stall  = force_stall;
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        kill_d     = kill_q;
        case (state_q)
            WB_IDLE: if (ml_valid && !grant_ml) state_d = WB_WAIT;
            WB_WAIT: if (grant_ml || !ml_valid) state_d = WB_IDLE;
            default: state_d = WB_IDLE;
        endcase
        if (grant_ml || !ml_valid) begin
            wait_cnt_d = '0;
        end else if (!at_max) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
        end
        // A younger pipeline write to the same rd makes the pending result stale.
        if (grant_ml) begin
            kill_d = 1'b0;
        end else if (ml_valid && pipe_wr && (pipe_rd == ml_rd)) begin
            kill_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= WB_IDLE;
            wait_cnt_q <= '0;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            kill_q     <= kill_d;
        end
    end

    // A granted ml result always owns the slot; a non-writing pipeline
    // instruction retires without one when ml is granted alongside it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_data_out  <= '0;
            rd_out       <= '0;
            is_write_out <= 1'b0;
        end else if (grant_ml) begin
            wb_data_out  <= ml_data;
            rd_out       <= ml_rd;
            is_write_out <= !kill_q && (ml_rd != '0);
        end else if (pipe_valid) begin
            wb_data_out  <= pipe_data;
            rd_out       <= pipe_rd;
            is_write_out <= pipe_wr;
        end else begin
            is_write_out <= 1'b0;
        end
    end

    assign dbg_state    = state_q;
    assign dbg_wait_cnt = wait_cnt_q;
    assign dbg_kill     = kill_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with MAX_WAIT = 4.
module tb_wb_port_arbiter;
    import wb_pkg::*;

    logic        clk;
    logic        reset;
    logic        pipe_valid, pipe_is_write;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_stall;
    logic        ml_valid;
    logic [4:0]  ml_rd;
    logic [31:0] ml_data;
    logic        ml_ready;
    logic [31:0] wb_data_out;
    logic [4:0]  rd_out;
    logic        is_write_out;
    wb_state_e   dbg_state;
    logic [2:0]  dbg_wait_cnt;
    logic        dbg_kill;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [36:0] exp_q[$];
    logic [31:0] rf[32];

    wb_port_arbiter #(.MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .pipe_valid(pipe_valid), .pipe_is_write(pipe_is_write),
        .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
        .ml_valid(ml_valid), .ml_rd(ml_rd), .ml_data(ml_data), .ml_ready(ml_ready),
        .wb_data_out(wb_data_out), .rd_out(rd_out), .is_write_out(is_write_out),
        .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt), .dbg_kill(dbg_kill)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic set_in(input logic pv, input logic pw, input logic [4:0] prd,
                          input logic [31:0] pd, input logic mv, input logic [4:0] mrd,
                          input logic [31:0] md);
        @(negedge clk);
        pipe_valid = pv; pipe_is_write = pw; pipe_rd = prd; pipe_data = pd;
        ml_valid = mv; ml_rd = mrd; ml_data = md;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: every register-file write must match the next expected entry
    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset && is_write_out) begin
                rf[rd_out] = wb_data_out;
                if (exp_q.size() == 0) begin
                    check("wb_unexpected", {27'd0, rd_out}, 32'hFFFF_FFFF);
                end else begin
                    logic [36:0] e;
                    e = exp_q.pop_front();
                    check("wb_rd", {27'd0, rd_out}, {27'd0, e[36:32]});
                    check("wb_data", wb_data_out, e[31:0]);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        pipe_valid = 0; pipe_is_write = 0; pipe_rd = 0; pipe_data = 0;
        ml_valid = 0; ml_rd = 0; ml_data = 0;

        // reset with random inputs
        for (int i = 0; i < 3; i++) begin
            set_in(1'($urandom_range(1)), 1'($urandom_range(1)), 5'($urandom_range(31)),
                   $urandom, 1'($urandom_range(1)), 5'($urandom_range(31)), $urandom);
            check("rst_ready", {31'd0, ml_ready}, 0);
            check("rst_stall", {31'd0, pipe_stall}, 0);
            tick();
            check("rst_we", {31'd0, is_write_out}, 0);
            check("rst_rd", {27'd0, rd_out}, 0);
            check("rst_data", wb_data_out, 0);
            check("rst_cnt", {29'd0, dbg_wait_cnt}, 0);
            check("rst_kill", {31'd0, dbg_kill}, 0);
            check("rst_state", 32'(dbg_state), 32'(WB_IDLE));
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;

        // first pipeline write after release
        set_in(1, 1, 3, 32'hDEADBEEF, 0, 0, 0);
        exp_q.push_back({5'd3, 32'hDEADBEEF});
        tick();
        check("first_rd", {27'd0, rd_out}, 3);
        check("first_we", {31'd0, is_write_out}, 1);

        // idle-slot grant
        set_in(0, 0, 0, 0, 1, 7, 32'h12);
        check("idle_ready", {31'd0, ml_ready}, 1);
        check("idle_stall", {31'd0, pipe_stall}, 0);
        exp_q.push_back({5'd7, 32'h12});
        tick();
        check("idle_rd", {27'd0, rd_out}, 7);
        check("idle_we", {31'd0, is_write_out}, 1);

        // starvation bound: ml rd 9 against continuous pipe writes
        for (int c = 1; c <= 4; c++) begin
            set_in(1, 1, 5'(c), 32'h100 + 32'(c), 1, 9, 32'h99);
            check("starve_ready", {31'd0, ml_ready}, 0);
            check("starve_stall", {31'd0, pipe_stall}, 0);
            check("starve_cnt", {29'd0, dbg_wait_cnt}, 32'(c - 1));
            exp_q.push_back({5'(c), 32'h100 + 32'(c)});
            tick();
            check("starve_out", {27'd0, rd_out}, 32'(c));
        end
        set_in(1, 1, 5, 32'h105, 1, 9, 32'h99);
        check("force_ready", {31'd0, ml_ready}, 1);
        check("force_stall", {31'd0, pipe_stall}, 1);
        check("force_state", 32'(dbg_state), 32'(WB_WAIT));
        exp_q.push_back({5'd9, 32'h99});
        tick();
        check("force_out", {27'd0, rd_out}, 9);
        set_in(1, 1, 5, 32'h105, 0, 0, 0);
        check("post_stall", {31'd0, pipe_stall}, 0);
        exp_q.push_back({5'd5, 32'h105});
        tick();
        check("stalled_out", {27'd0, rd_out}, 5);
        check("stalled_cnt", {29'd0, dbg_wait_cnt}, 0);

        // WAW kill on rd 5
        set_in(1, 1, 5, 32'hAA, 1, 5, 32'h55);
        check("waw_ready0", {31'd0, ml_ready}, 0);
        exp_q.push_back({5'd5, 32'hAA});
        tick();
        check("waw_kill", {31'd0, dbg_kill}, 1);
        set_in(0, 0, 0, 0, 1, 5, 32'h55);
        check("waw_ready1", {31'd0, ml_ready}, 1);
        tick();
        check("waw_we", {31'd0, is_write_out}, 0);
        check("waw_kill_clr", {31'd0, dbg_kill}, 0);
        check("waw_rf5", rf[5], 32'hAA);

        // x0 pipe write does not block ml
        set_in(1, 1, 0, 32'h77, 1, 12, 32'h34);
        check("x0p_ready", {31'd0, ml_ready}, 1);
        exp_q.push_back({5'd12, 32'h34});
        tick();
        check("x0p_rd", {27'd0, rd_out}, 12);
        // ml_rd 0 accepted and discarded
        set_in(0, 0, 0, 0, 1, 0, 32'h56);
        check("x0m_ready", {31'd0, ml_ready}, 1);
        tick();
        check("x0m_we", {31'd0, is_write_out}, 0);
        // store alongside ml: ml owns the slot
        set_in(1, 0, 8, 32'h11, 1, 13, 32'h66);
        check("store_ready", {31'd0, ml_ready}, 1);
        exp_q.push_back({5'd13, 32'h66});
        tick();
        check("store_rd", {27'd0, rd_out}, 13);

        // mid-wait reset
        set_in(1, 1, 6, 32'h60, 1, 6, 32'hB0);
        exp_q.push_back({5'd6, 32'h60});
        tick();
        set_in(1, 1, 2, 32'h61, 1, 6, 32'hB0);
        exp_q.push_back({5'd2, 32'h61});
        tick();
        set_in(1, 1, 3, 32'h62, 1, 6, 32'hB0);
        exp_q.push_back({5'd3, 32'h62});
        tick();
        check("mid_cnt", {29'd0, dbg_wait_cnt}, 3);
        check("mid_kill", {31'd0, dbg_kill}, 1);
        @(negedge clk);
        pipe_valid = 0; pipe_is_write = 0;
        reset = 1'b0;
        #1;
        check("mid_rst_cnt", {29'd0, dbg_wait_cnt}, 0);
        check("mid_rst_kill", {31'd0, dbg_kill}, 0);
        check("mid_rst_ready", {31'd0, ml_ready}, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rel_ready", {31'd0, ml_ready}, 1);
        exp_q.push_back({5'd6, 32'hB0});
        tick();
        check("rel_we", {31'd0, is_write_out}, 1);
        check("rel_rd", {27'd0, rd_out}, 6);

        set_in(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
